fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-002 Ports SHALL be as follows:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: synchronous active-low reset.
- freeze_in, input, 1: hazard stall; holds the PC and the IF/ID outputs.
- branch_taken_in, input, 1: redirects the PC to branch_addr_in.
- branch_addr_in, input, 32: byte address of the branch target.
- flush_in, input, 1: kills the instruction held in IF/ID.
- inst_in, input, 32: instruction word returned combinationally by the instruction memory.
- imem_addr_out, output, 32: current PC driven to the instruction memory.
- pc_out, output, 32: IF/ID registered PC+4 of the held instruction.
- inst_out, output, 32: IF/ID registered instruction.
- valid_out, output, 1: IF/ID holds a live instruction.
- fetch_cnt_out, output, 32: fetched-instruction count (see REQ-016).
- stall_cnt_out, output, 32: stall-cycle count (see REQ-016).

Function
REQ-003 PC SHALL be a 32-bit register; imem_addr_out SHALL equal PC combinationally, with bits [1:0] always 0.
REQ-004 Each cycle with rst_n=1, the next PC SHALL be chosen by priority:
- branch_taken_in=1: next PC = {branch_addr_in[31:2],2'b00}.
- else freeze_in=1: PC holds.
- else: next PC = PC+4, modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
REQ-005 The IF/ID register SHALL update by priority:
- branch_taken_in=1 or flush_in=1: inst_out=0x00000000, pc_out=0, valid_out=0.
- else freeze_in=1: all IF/ID outputs hold.
- else: inst_out<=inst_in, pc_out<=PC+4, valid_out<=1.
REQ-006 Latency SHALL be one cycle: the instruction at address A, presented on imem_addr_out in cycle n, SHALL appear on inst_out in cycle n+1 with pc_out=A+4.
REQ-007 A branch asserted together with freeze_in SHALL still redirect the PC and squash IF/ID; a branch is never lost to a stall.
REQ-008 flush_in alone SHALL NOT alter PC sequencing; the PC advances or holds per REQ-004.
REQ-009 After a branch in cycle n, the instruction at the target SHALL appear on inst_out in cycle n+2, and valid_out SHALL be 0 in cycle n+1.
REQ-010 Sustained freeze_in SHALL hold the PC and IF/ID indefinitely with no drift.
REQ-011 inst_in SHALL be treated as combinational from imem_addr_out; the block SHALL add no wait states.

Reset
REQ-012 With rst_n=0 at a rising edge:
- PC SHALL become 0x00000000.
- inst_out, pc_out and valid_out SHALL become 0.
- fetch_cnt_out and stall_cnt_out SHALL become 0.
REQ-013 Reset SHALL take priority over branch, flush and freeze.
REQ-014 Reset asserted mid-stall or mid-branch SHALL discard that pending operation entirely.
REQ-015 The first fetch from address 0 SHALL occur in the first cycle after rst_n returns to 1.

Configuration
REQ-016 With macro FETCH_PERF_CNT_EN defined:
- fetch_cnt_out SHALL increment by 1 on each edge where valid_out is loaded with 1.
- stall_cnt_out SHALL increment by 1 on each edge with freeze_in=1 and branch_taken_in=0.
- Both counters SHALL wrap modulo 2^32.
REQ-017 With FETCH_PERF_CNT_EN undefined, both counter outputs SHALL be constant 0 and no counter registers SHALL be synthesized.

Verification
REQ-018 Reset, then 4 free-run cycles with memory words W0..W3 -> imem_addr_out=0,4,8,12; inst_out=W0..W3 one cycle later; pc_out=4,8,12,16; valid_out=1.
REQ-019 freeze_in=1 for 3 cycles at PC=0x8 -> imem_addr_out stays 0x8; inst_out/pc_out frozen at the word from 0x4/0x8; stall_cnt_out +3 when FETCH_PERF_CNT_EN is defined.
REQ-020 branch_taken_in=1 with branch_addr_in=0x103 while freeze_in=1 -> next imem_addr_out=0x100; valid_out=0 the next cycle; word at 0x100 on inst_out with pc_out=0x104 one cycle later.
REQ-021 flush_in=1 for one cycle at PC=0x20 -> inst_out=0, valid_out=0; imem_addr_out=0x24; normal fetch resumes.
REQ-022 Force PC to 0xFFFFFFFC via branch, then free-run -> imem_addr_out=0x00000000 on the following cycle; pc_out=0x00000000 for that word.
REQ-023 rst_n=0 asserted the cycle after a branch to 0x40 -> PC=0, all outputs 0; fetch restarts at 0 rather than 0x40.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with program counter and IF/ID register.
//
// Drives the current PC to a combinational instruction memory and registers the
// returned word together with PC+4 into the IF/ID pipeline register.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   freeze_in       hazard stall: holds the PC and the IF/ID register
//   branch_taken_in redirect the PC to branch_addr_in (word aligned)
//   branch_addr_in  byte address of the branch target
//   flush_in        kill the instruction being loaded into IF/ID
//   inst_in         instruction word for imem_addr_out (same cycle)
//   imem_addr_out   current PC, bits [1:0] always zero
//   pc_out          IF/ID PC+4 of the held instruction
//   inst_out        IF/ID instruction
//   valid_out       IF/ID holds a live instruction
//   fetch_cnt_out   fetched-instruction count (0 unless FETCH_PERF_CNT_EN)
//   stall_cnt_out   stall-cycle count (0 unless FETCH_PERF_CNT_EN)
//
// Handshake: there is no back-pressure. valid_out qualifies inst_out/pc_out
// in every cycle; freeze_in is the only hold mechanism and it is obeyed on
// the same edge it is sampled.
//
// Optional feature: define FETCH_PERF_CNT_EN to build the two performance
// counters; otherwise both counter outputs are tied to zero.
module fetch_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        freeze_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_addr_in,
    input  logic        flush_in,
    input  logic [31:0] inst_in,
    output logic [31:0] imem_addr_out,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        valid_out,
    output logic [31:0] fetch_cnt_out,
    output logic [31:0] stall_cnt_out
);

    logic [31:0] pc_q,    pc_d;
    logic [31:0] ifid_pc_q,   ifid_pc_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] pc_plus4;
    logic        load_ifid;

    // Wraps naturally modulo 2^32.
    assign pc_plus4 = pc_q + 32'd4;

    // A live instruction enters IF/ID only when nothing squashes or holds it.
    assign load_ifid = !branch_taken_in && !flush_in && !freeze_in;

    always_comb begin
        pc_d = pc_q;
        if (branch_taken_in) begin
            // Branch wins over freeze so a redirect is never lost to a stall.
            pc_d = {branch_addr_in[31:2], 2'b00};
        end else if (!freeze_in) begin
            pc_d = pc_plus4;
        end
    end

    always_comb begin
        ifid_pc_d    = ifid_pc_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_valid_d = ifid_valid_q;
        if (branch_taken_in || flush_in) begin
            ifid_pc_d    = 32'd0;
            ifid_inst_d  = 32'd0;
            ifid_valid_d = 1'b0;
        end else if (!freeze_in) begin
            ifid_pc_d    = pc_plus4;
            ifid_inst_d  = inst_in;
            ifid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= 32'd0;
            ifid_pc_q    <= 32'd0;
            ifid_inst_q  <= 32'd0;
            ifid_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign imem_addr_out = pc_q;
    assign pc_out        = ifid_pc_q;
    assign inst_out      = ifid_inst_q;
    assign valid_out     = ifid_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (load_ifid) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        // A branch during a freeze is a redirect, not a stall cycle.
        if (freeze_in && !branch_taken_in) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt_out = fetch_cnt_q;
    assign stall_cnt_out = stall_cnt_q;
`else
    assign fetch_cnt_out = 32'd0;
    assign stall_cnt_out = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage.
// A combinational memory model returns word(addr) for imem_addr_out. The
// driver applies one cycle of stimulus at the falling edge, checks the
// current PC, and pushes the expected IF/ID contents after the next rising
// edge; the monitor pops and compares shortly after every rising edge.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        freeze_in;
    logic        branch_taken_in;
    logic [31:0] branch_addr_in;
    logic        flush_in;
    logic [31:0] inst_in;
    logic [31:0] imem_addr_out;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        valid_out;
    logic [31:0] fetch_cnt_out;
    logic [31:0] stall_cnt_out;

    int n_tests;
    int n_fail;

    // {valid, pc, inst}
    logic [64:0] exp_q[$];
    // {fetch_cnt, stall_cnt}
    logic [63:0] cnt_q[$];

    logic [31:0] m_fetch;
    logic [31:0] m_stall;

    fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .freeze_in       (freeze_in),
        .branch_taken_in (branch_taken_in),
        .branch_addr_in  (branch_addr_in),
        .flush_in        (flush_in),
        .inst_in         (inst_in),
        .imem_addr_out   (imem_addr_out),
        .pc_out          (pc_out),
        .inst_out        (inst_out),
        .valid_out       (valid_out),
        .fetch_cnt_out   (fetch_cnt_out),
        .stall_cnt_out   (stall_cnt_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // instruction memory: combinational from the PC
    assign inst_in = word(imem_addr_out);

    // driver: one cycle of stimulus plus its expected IF/ID result
    task automatic step(input logic rst, input logic fr, input logic br,
                        input logic [31:0] ba, input logic fl,
                        input logic chk_a, input logic [31:0] ea,
                        input logic ev, input logic [31:0] epc,
                        input logic [31:0] einst);
        @(negedge clk);
        rst_n           = rst;
        freeze_in       = fr;
        branch_taken_in = br;
        branch_addr_in  = ba;
        flush_in        = fl;
        if (chk_a) begin
            n_tests++;
            if (imem_addr_out !== ea) begin
                n_fail++;
                $display("FAIL imem_addr got %h exp %h at %0t", imem_addr_out, ea, $time);
            end
        end
        exp_q.push_back({ev, epc, einst});
        if (!rst) begin
            m_fetch = 32'd0;
            m_stall = 32'd0;
        end else begin
            if (!br && !fl && !fr) m_fetch = m_fetch + 32'd1;
            if (fr && !br) m_stall = m_stall + 32'd1;
        end
`ifdef FETCH_PERF_CNT_EN
        cnt_q.push_back({m_fetch, m_stall});
`else
        cnt_q.push_back(64'd0);
`endif
    endtask

    // monitor / scoreboard
    always @(posedge clk) begin
        logic [64:0] e;
        logic [63:0] c;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            c = cnt_q.pop_front();
            n_tests++;
            if (valid_out !== e[64]) begin
                n_fail++;
                $display("FAIL valid_out got %b exp %b at %0t", valid_out, e[64], $time);
            end
            n_tests++;
            if (pc_out !== e[63:32]) begin
                n_fail++;
                $display("FAIL pc_out got %h exp %h at %0t", pc_out, e[63:32], $time);
            end
            n_tests++;
            if (inst_out !== e[31:0]) begin
                n_fail++;
                $display("FAIL inst_out got %h exp %h at %0t", inst_out, e[31:0], $time);
            end
            n_tests++;
            if (fetch_cnt_out !== c[63:32]) begin
                n_fail++;
                $display("FAIL fetch_cnt got %h exp %h at %0t", fetch_cnt_out, c[63:32], $time);
            end
            n_tests++;
            if (stall_cnt_out !== c[31:0]) begin
                n_fail++;
                $display("FAIL stall_cnt got %h exp %h at %0t", stall_cnt_out, c[31:0], $time);
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_fetch = 32'd0;
        m_stall = 32'd0;
        rst_n = 1'b0; freeze_in = 1'b0; branch_taken_in = 1'b0;
        branch_addr_in = 32'd0; flush_in = 1'b0;

        // reset, with branch and freeze asserted to show reset priority
        step(0, 1, 1, 32'h80, 1, 0, 32'h0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 32'h0,  0, 1, 32'h0, 0, 32'h0, 32'h0);

        // free run from 0
        step(1, 0, 0, 32'h0, 0, 1, 32'h0, 1, 32'h4,  word(32'h0));
        step(1, 0, 0, 32'h0, 0, 1, 32'h4, 1, 32'h8,  word(32'h4));
        step(1, 0, 0, 32'h0, 0, 1, 32'h8, 1, 32'hC,  word(32'h8));
        step(1, 0, 0, 32'h0, 0, 1, 32'hC, 1, 32'h10, word(32'hC));

        // branch back to 0x4, fetch it, then freeze 3 cycles at PC=0x8
        step(1, 0, 1, 32'h4, 0, 1, 32'h10, 0, 32'h0, 32'h0);
        step(1, 0, 0, 32'h0, 0, 1, 32'h4,  1, 32'h8, word(32'h4));
        step(1, 1, 0, 32'h0, 0, 1, 32'h8,  1, 32'h8, word(32'h4));
        step(1, 1, 0, 32'h0, 0, 1, 32'h8,  1, 32'h8, word(32'h4));
        step(1, 1, 0, 32'h0, 0, 1, 32'h8,  1, 32'h8, word(32'h4));

        // branch to 0x103 during freeze -> 0x100, squashed for one cycle
        step(1, 1, 1, 32'h103, 0, 1, 32'h8,   0, 32'h0,   32'h0);
        step(1, 0, 0, 32'h0,   0, 1, 32'h100, 1, 32'h104, word(32'h100));
        step(1, 0, 0, 32'h0,   0, 1, 32'h104, 1, 32'h108, word(32'h104));

        // go to 0x20, flush one cycle there, PC keeps advancing
        step(1, 0, 1, 32'h20, 0, 1, 32'h108, 0, 32'h0,  32'h0);
        step(1, 0, 0, 32'h0,  1, 1, 32'h20,  0, 32'h0,  32'h0);
        step(1, 0, 0, 32'h0,  0, 1, 32'h24,  1, 32'h28, word(32'h24));
        step(1, 0, 0, 32'h0,  0, 1, 32'h28,  1, 32'h2C, word(32'h28));

        // PC wrap from 0xFFFFFFFC (unaligned target bits dropped)
        step(1, 0, 1, 32'hFFFF_FFFF, 0, 1, 32'h2C,        0, 32'h0, 32'h0);
        step(1, 0, 0, 32'h0,         0, 1, 32'hFFFF_FFFC, 1, 32'h0, word(32'hFFFF_FFFC));
        step(1, 0, 0, 32'h0,         0, 1, 32'h0,         1, 32'h4, word(32'h0));

        // branch to 0x40 then reset the next cycle (with freeze pending)
        step(1, 0, 1, 32'h40, 0, 1, 32'h4,  0, 32'h0, 32'h0);
        step(0, 1, 0, 32'h0,  0, 1, 32'h40, 0, 32'h0, 32'h0);
        step(1, 0, 0, 32'h0,  0, 1, 32'h0,  1, 32'h4, word(32'h0));
        step(1, 0, 0, 32'h0,  0, 1, 32'h4,  1, 32'h8, word(32'h4));

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
